// File: rtl/um_pkg.sv
// Shared definitions for the UM beacon path: beat tags, PTP ethertype,
// beacon message types and the beacon field layout inside a 128-bit payload.
// The beacon reporter packs its fields with the same offsets.
package um_pkg;

  localparam int unsigned DATA_W    = 134;
  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned MAC_W     = 48;
  localparam int unsigned CNT_W     = 4;

  // Beat tag in data[133:132]
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [15:0] PTP_ETHERTYPE = 16'h88f7;

  // Beacon message types carried in the messageType nibble
  localparam logic [3:0] MSG_BEACON_REPORT = 4'he;
  localparam logic [3:0] MSG_BEACON_QUERY  = 4'hf;
  localparam logic [3:0] MSG_BEACON_UPDATE = 4'hd;

  // Header fields in the classified beat
  localparam int unsigned HDR_SMAC_LSB  = 32;
  localparam int unsigned HDR_ETYPE_LSB = 16;
  localparam int unsigned HDR_MTYPE_LSB = 8;

  // Beacon field offsets; bits [78:64] are reserved
  localparam int unsigned BCN_MAC_LSB    = 80;
  localparam int unsigned BCN_DIR_BIT    = 79;
  localparam int unsigned BCN_DEPTH_LSB  = 48;
  localparam int unsigned BCN_PARA_LSB   = 32;
  localparam int unsigned BCN_PERIOD_LSB = 0;

  // One delay-line entry
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              valid_wr;
  } lu_beat_t;

  // Beacon configuration register set
  typedef struct packed {
    logic [MAC_W-1:0] mac;
    logic             dir;
    logic [15:0]      depth;
    logic [15:0]      para;
    logic [31:0]      period;
  } bcn_cfg_t;

  // Pull the beacon fields out of a payload word
  function automatic bcn_cfg_t bcn_extract(input logic [PAYLOAD_W-1:0] pl);
    bcn_cfg_t cfg;
    cfg.mac    = pl[BCN_MAC_LSB +: MAC_W];
    cfg.dir    = pl[BCN_DIR_BIT];
    cfg.depth  = pl[BCN_DEPTH_LSB +: 16];
    cfg.para   = pl[BCN_PARA_LSB +: 16];
    cfg.period = pl[BCN_PERIOD_LSB +: 32];
    return cfg;
  endfunction

endpackage

// File: rtl/lupdate_dly3.sv
// Three-stage beat delay line. Every stage shifts each cycle; each entry can
// have its wr/valid_wr cleared as it moves so a consumed packet never reaches
// the output.
//   in_beat  : beat entering stage 1
//   kill_in  : clear strobes of the beat entering stage 1
//   kill_s1  : clear strobes of the stage-1 entry moving to stage 2
//   kill_s2  : clear strobes of the stage-2 entry moving to stage 3
//   out_beat : stage 3
module lupdate_dly3
  import um_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  lu_beat_t in_beat,
  input  logic     kill_in,
  input  logic     kill_s1,
  input  logic     kill_s2,
  output lu_beat_t out_beat
);

  lu_beat_t s1_q, s2_q, s3_q;
  lu_beat_t s1_d, s2_d, s3_d;

  // Next-stage values with optional strobe kill
  always_comb begin
    s1_d = in_beat;
    s2_d = s1_q;
    s3_d = s2_q;
    if (kill_in) begin
      s1_d.wr       = 1'b0;
      s1_d.valid_wr = 1'b0;
    end
    if (kill_s1) begin
      s2_d.wr       = 1'b0;
      s2_d.valid_wr = 1'b0;
    end
    if (kill_s2) begin
      s3_d.wr       = 1'b0;
      s3_d.valid_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_beat = s3_q;

endmodule

// File: rtl/lupdate.sv
// Beacon update receiver. Watches the packet stream for beacon update messages
// addressed to this node, consumes them and latches the beacon registers;
// everything else is forwarded with a fixed 3-cycle latency.
//   in_lu_data*          : input beat stream (tag in [133:132], payload [127:0])
//   in_local_mac_id      : this node's MAC, matched against the header smac
//   out_lu_data*         : delayed stream with update packets removed
//   direction..period    : committed beacon registers
//   beacon_update_master : toggles once per committed update
//   update_cnt           : committed updates
//   update_err_cnt       : malformed (short or unterminated) update packets
module lupdate
  import um_pkg::*;
#(
  parameter logic [7:0]  LMID         = 8'd12,
  parameter logic [3:0]  UPD_MSG_TYPE = MSG_BEACON_UPDATE,
  parameter logic [15:0] PTP_ETYPE    = PTP_ETHERTYPE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_lu_data_wr,
  input  logic [DATA_W-1:0]    in_lu_data,
  input  logic                 in_lu_data_valid,
  input  logic                 in_lu_data_valid_wr,
  input  logic [MAC_W-1:0]     in_local_mac_id,
  output logic                 out_lu_data_wr,
  output logic [DATA_W-1:0]    out_lu_data,
  output logic                 out_lu_data_valid,
  output logic                 out_lu_data_valid_wr,
  output logic                 direction,
  output logic [15:0]          token_bucket_para,
  output logic [15:0]          token_bucket_depth,
  output logic [MAC_W-1:0]     direct_mac_addr,
  output logic [31:0]          time_slot_period,
  output logic                 beacon_update_master,
  output logic [63:0]          update_cnt,
  output logic [31:0]          update_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_UPD, S_PASS} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(15);
  localparam logic [CNT_W-1:0] CLASSIFY_BEAT = CNT_W'(2);
  localparam logic [CNT_W-1:0] CFG_BEAT      = CNT_W'(6);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // index of the next beat
  logic               cap_q, cap_d;       // beat 6 staged
  bcn_cfg_t           stage_q, stage_d;
  bcn_cfg_t           cfg_q, cfg_d;
  logic               toggle_q, toggle_d;
  logic [63:0]        upd_cnt_q, upd_cnt_d;
  logic [31:0]        err_cnt_q, err_cnt_d;

  logic [1:0]           tag_c;
  logic [PAYLOAD_W-1:0] payload_c;
  logic                 is_head_c, is_tail_c, hdr_match_c;
  bcn_cfg_t             beat_cfg_c;
  logic                 kill_in_c, kill_s1_c, kill_s2_c;
  lu_beat_t             dly_in_c, dly_out;

  assign tag_c       = in_lu_data[DATA_W-1 -: 2];
  assign payload_c   = in_lu_data[PAYLOAD_W-1:0];
  assign is_head_c   = (tag_c == TAG_HEAD);
  assign is_tail_c   = (tag_c == TAG_TAIL);
  assign beat_cfg_c  = bcn_extract(payload_c);
  // dmac [127:80] is deliberately not compared
  assign hdr_match_c = (payload_c[HDR_SMAC_LSB +: MAC_W] == in_local_mac_id) &&
                       (payload_c[HDR_ETYPE_LSB +: 16] == PTP_ETYPE) &&
                       (payload_c[HDR_MTYPE_LSB +: 4] == UPD_MSG_TYPE);

  assign dly_in_c = '{wr:       in_lu_data_wr,
                      data:     in_lu_data,
                      valid:    in_lu_data_valid,
                      valid_wr: in_lu_data_valid_wr};

  // Parser next-state, staging and commit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    stage_d   = stage_q;
    cfg_d     = cfg_q;
    toggle_d  = toggle_q;
    upd_cnt_d = upd_cnt_q;
    err_cnt_d = err_cnt_q;
    kill_in_c = 1'b0;
    kill_s1_c = 1'b0;
    kill_s2_c = 1'b0;

    if (in_lu_data_wr) begin
      if (is_head_c)              cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);

      if (is_head_c) begin
        // A head always restarts parsing; an open update is abandoned
        if (state_q == S_UPD) err_cnt_d = err_cnt_q + 32'd1;
        cap_d   = 1'b0;
        state_d = S_HDR;
      end else begin
        case (state_q)
          S_HDR: begin
            if (cnt_q == CLASSIFY_BEAT && hdr_match_c) begin
              // Beats 0..2 are in flight: entering, stage 1, stage 2
              kill_in_c = 1'b1;
              kill_s1_c = 1'b1;
              kill_s2_c = 1'b1;
              if (is_tail_c) begin
                err_cnt_d = err_cnt_q + 32'd1;
                state_d   = S_IDLE;
              end else begin
                state_d   = S_UPD;
              end
            end else if (is_tail_c) begin
              state_d = S_IDLE;
            end else if (cnt_q >= CLASSIFY_BEAT) begin
              state_d = S_PASS;
            end
          end
          S_UPD: begin
            kill_in_c = 1'b1;
            if (cnt_q == CFG_BEAT) begin
              stage_d = beat_cfg_c;
              cap_d   = 1'b1;
            end
            if (is_tail_c) begin
              if (cnt_q >= CFG_BEAT && (cap_q || cnt_q == CFG_BEAT)) begin
                // Tail may itself be beat 6, so bypass the staging register
                cfg_d     = (cnt_q == CFG_BEAT) ? beat_cfg_c : stage_q;
                toggle_d  = ~toggle_q;
                upd_cnt_d = upd_cnt_q + 64'd1;
              end else begin
                err_cnt_d = err_cnt_q + 32'd1;
              end
              cap_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
          S_PASS: begin
            if (is_tail_c) state_d = S_IDLE;
          end
          default: ;  // IDLE: stray non-head beats just pass through
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cap_q     <= 1'b0;
      stage_q   <= '0;
      cfg_q     <= '0;
      toggle_q  <= 1'b0;
      upd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      stage_q   <= stage_d;
      cfg_q     <= cfg_d;
      toggle_q  <= toggle_d;
      upd_cnt_q <= upd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  lupdate_dly3 u_dly3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_beat  (dly_in_c),
    .kill_in  (kill_in_c),
    .kill_s1  (kill_s1_c),
    .kill_s2  (kill_s2_c),
    .out_beat (dly_out)
  );

  assign out_lu_data_wr       = dly_out.wr;
  assign out_lu_data          = dly_out.data;
  assign out_lu_data_valid    = dly_out.valid;
  assign out_lu_data_valid_wr = dly_out.valid_wr;

  assign direction            = cfg_q.dir;
  assign token_bucket_para    = cfg_q.para;
  assign token_bucket_depth   = cfg_q.depth;
  assign direct_mac_addr      = cfg_q.mac;
  assign time_slot_period     = cfg_q.period;
  assign beacon_update_master = toggle_q;
  assign update_cnt           = upd_cnt_q;
  assign update_err_cnt       = err_cnt_q;

endmodule
